// File: rtl/rx_pbm_ring_if.sv
// -----------------------------------------------------------------------------
// rx_pbm_ring_if
//   Bundles the handshake signals of the RX packet buffer ring.
//   Write side : parser payload beats (wdata/wvalid/wlast/werror) with the
//                end-of-packet metadata (meta_data/meta_valid) and the ring's
//                ready/consumed replies.
//   Replay side: AXI-Stream toward crypto/DMA (tdata/tvalid/tlast/tready)
//                plus the byte length of the packet being replayed.
//   Modports   : master = parser and downstream consumer environment,
//                slave  = the ring itself.
// -----------------------------------------------------------------------------
interface rx_pbm_ring_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] i_pbm_wdata;
   logic                  i_pbm_wvalid;
   logic                  i_pbm_wlast;
   logic                  i_pbm_werror;
   logic                  o_pbm_ready;
   logic [15:0]           i_meta_data;
   logic                  i_meta_valid;
   logic                  o_meta_ready;

   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tlast;
   logic                  m_axis_tready;
   logic [15:0]           o_rd_len;

   modport master (
      output i_pbm_wdata, i_pbm_wvalid, i_pbm_wlast, i_pbm_werror,
             i_meta_data, i_meta_valid, m_axis_tready,
      input  o_pbm_ready, o_meta_ready, m_axis_tdata, m_axis_tvalid,
             m_axis_tlast, o_rd_len
   );

   modport slave (
      input  i_pbm_wdata, i_pbm_wvalid, i_pbm_wlast, i_pbm_werror,
             i_meta_data, i_meta_valid, m_axis_tready,
      output o_pbm_ready, o_meta_ready, m_axis_tdata, m_axis_tvalid,
             m_axis_tlast, o_rd_len
   );
endinterface

// File: rtl/rx_pbm_ring.sv
// -----------------------------------------------------------------------------
// rx_pbm_ring
//   Packet buffer memory behind the RX header parser. Payload words are stored
//   speculatively in a circular RAM; on the last beat the packet is committed
//   (clean, legal metadata, fits, descriptor slot free, enough words for the
//   byte length) or rolled back. Committed packets are replayed in order on an
//   AXI-Stream master together with their byte length. The parser is never
//   back-pressured: lack of space drops the packet instead.
// Ports
//   clk          : single rising-edge clock
//   rst_n        : synchronous active-low reset
//   bus          : rx_pbm_ring_if.slave (write side, metadata, AXI-Stream out)
//   o_commit_cnt : committed packets, wraps
//   o_drop_cnt   : dropped packets, wraps
// Parameters
//   DATA_WIDTH word width, ADDR_WIDTH log2 RAM depth, DESC_DEPTH descriptor
//   FIFO entries (power of 2, at least 2)
// -----------------------------------------------------------------------------
module rx_pbm_ring #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int DESC_DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   rx_pbm_ring_if.slave bus,
   output logic [15:0]  o_commit_cnt,
   output logic [15:0]  o_drop_cnt
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int PW    = ADDR_WIDTH + 1;               // pointer width, extra wrap bit
   localparam int DW    = $clog2(DESC_DEPTH);
   localparam int LW    = (PW + 2 > 16) ? PW + 2 : 16;  // length compare width

   typedef enum logic [1:0] {W_IDLE, W_STORE, W_DISCARD} wstate_e;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM}  rstate_e;

   typedef struct packed {
      logic [PW-1:0] start;
      logic [PW-1:0] words;
      logic [15:0]   len;
   } desc_t;

   // storage
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   desc_t                 desc_mem [DESC_DEPTH];

   // write side
   wstate_e       wstate_q, wstate_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] wr_tmp_q, wr_tmp_d;
   logic [PW-1:0] word_cnt_q, word_cnt_d;
   logic          overflow_q, overflow_d;
   logic          pbm_ready_q;
   logic [15:0]   commit_cnt_q, commit_cnt_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          accept, space_ok, mem_we;
   logic [PW-1:0] used, cnt_cur, tmp_cur;
   logic          ovf_cur, commit_ok, push;
   desc_t         push_desc;

   // descriptor FIFO
   logic [DW:0]   dwp_q, drp_q;
   logic          desc_full, desc_empty, pop;

   // read side
   rstate_e               rstate_q, rstate_d;
   desc_t                 cur_q, cur_d;
   logic [PW-1:0]         rd_idx_q, rd_idx_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  rd_en, drain;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;

   assign accept     = bus.i_pbm_wvalid && pbm_ready_q;
   // used never exceeds DEPTH, so the extra pointer bit keeps full and empty apart
   assign used       = wr_tmp_q - rd_ptr_q;
   assign space_ok   = used < PW'(DEPTH);
   assign desc_empty = (dwp_q == drp_q);
   assign desc_full  = (dwp_q[DW] != drp_q[DW]) && (dwp_q[DW-1:0] == drp_q[DW-1:0]);

   // ---------------------------------------------------------------------------
   // Write FSM: store, overflow-discard, commit or roll back on the last beat
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wstate_d     = wstate_q;
      wr_ptr_d     = wr_ptr_q;
      wr_tmp_d     = wr_tmp_q;
      word_cnt_d   = word_cnt_q;
      overflow_d   = overflow_q;
      commit_cnt_d = commit_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      mem_we       = 1'b0;
      push         = 1'b0;
      commit_ok    = 1'b0;
      // a packet starting in W_IDLE begins with a fresh count and overflow flag
      cnt_cur      = (wstate_q == W_IDLE) ? '0 : word_cnt_q;
      ovf_cur      = (wstate_q == W_IDLE) ? 1'b0 : overflow_q;
      tmp_cur      = wr_tmp_q;

      if (accept) begin
         if (wstate_q != W_DISCARD) begin
            if (space_ok) begin
               mem_we   = 1'b1;
               tmp_cur  = wr_tmp_q + PW'(1);
               cnt_cur  = cnt_cur + PW'(1);
               wstate_d = W_STORE;
            end else begin
               ovf_cur  = 1'b1;
               wstate_d = W_DISCARD;
            end
         end
         wr_tmp_d   = tmp_cur;
         word_cnt_d = cnt_cur;
         overflow_d = ovf_cur;

         if (bus.i_pbm_wlast) begin
            wstate_d  = W_IDLE;
            commit_ok = !bus.i_pbm_werror && bus.i_meta_valid && !ovf_cur && !desc_full &&
                        (LW'({cnt_cur, 2'b00}) >= LW'(bus.i_meta_data));
            if (commit_ok) begin
               wr_ptr_d     = tmp_cur;
               push         = 1'b1;
               commit_cnt_d = commit_cnt_q + 16'd1;
            end else begin
               wr_tmp_d     = wr_ptr_q;
               drop_cnt_d   = drop_cnt_q + 16'd1;
            end
         end
      end

      push_desc = '{start: wr_ptr_q, words: cnt_cur, len: bus.i_meta_data};
   end

   // ---------------------------------------------------------------------------
   // Read FSM: the RAM read register doubles as the AXI-Stream output register
   // ---------------------------------------------------------------------------
   assign drain   = tvalid_q && bus.m_axis_tready;
   assign rd_addr = cur_q.start[ADDR_WIDTH-1:0] + rd_idx_q[ADDR_WIDTH-1:0];

   always_comb begin
      rstate_d = rstate_q;
      cur_d    = cur_q;
      rd_idx_d = rd_idx_q;
      rd_ptr_d = rd_ptr_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      pop      = 1'b0;
      rd_en    = 1'b0;

      case (rstate_q)
         R_IDLE: begin
            if (!desc_empty) begin
               pop      = 1'b1;
               cur_d    = desc_mem[drp_q[DW-1:0]];
               rd_idx_d = '0;
               rstate_d = R_FETCH;
            end
         end
         R_FETCH: begin
            rd_en    = 1'b1;
            rd_idx_d = PW'(1);
            tvalid_d = 1'b1;
            tlast_d  = (cur_q.words == PW'(1));
            rstate_d = R_STREAM;
         end
         R_STREAM: begin
            if (drain && tlast_q) begin
               // whole packet space is released at once on the final handshake
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               rd_ptr_d = cur_q.start + cur_q.words;
               rstate_d = R_IDLE;
            end else if (!tvalid_q || drain) begin
               if (rd_idx_q != cur_q.words) begin
                  rd_en    = 1'b1;
                  rd_idx_d = rd_idx_q + PW'(1);
                  tvalid_d = 1'b1;
                  tlast_d  = (rd_idx_q + PW'(1) == cur_q.words);
               end else begin
                  tvalid_d = 1'b0;
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         wstate_q     <= W_IDLE;
         wr_ptr_q     <= '0;
         wr_tmp_q     <= '0;
         word_cnt_q   <= '0;
         overflow_q   <= 1'b0;
         pbm_ready_q  <= 1'b0;
         commit_cnt_q <= '0;
         drop_cnt_q   <= '0;
         dwp_q        <= '0;
         drp_q        <= '0;
         rstate_q     <= R_IDLE;
         cur_q        <= '0;
         rd_idx_q     <= '0;
         rd_ptr_q     <= '0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         wstate_q     <= wstate_d;
         wr_ptr_q     <= wr_ptr_d;
         wr_tmp_q     <= wr_tmp_d;
         word_cnt_q   <= word_cnt_d;
         overflow_q   <= overflow_d;
         pbm_ready_q  <= 1'b1;
         commit_cnt_q <= commit_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         if (push) dwp_q <= dwp_q + (DW+1)'(1);
         if (pop)  drp_q <= drp_q + (DW+1)'(1);
         rstate_q     <= rstate_d;
         cur_q        <= cur_d;
         rd_idx_q     <= rd_idx_d;
         rd_ptr_q     <= rd_ptr_d;
         tvalid_q     <= tvalid_d;
         tlast_q      <= tlast_d;
         if (rd_en) rd_data_q <= mem[rd_addr];
      end
   end

   // NOTE: RAM and descriptor arrays are not reset; the pointers alone define valid contents.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_tmp_q[ADDR_WIDTH-1:0]] <= bus.i_pbm_wdata;
      if (push)   desc_mem[dwp_q[DW-1:0]]       <= push_desc;
   end

   assign bus.o_pbm_ready   = pbm_ready_q;
   assign bus.o_meta_ready  = bus.i_pbm_wvalid && bus.i_pbm_wlast && pbm_ready_q;
   assign bus.m_axis_tdata  = rd_data_q;
   assign bus.m_axis_tvalid = tvalid_q;
   assign bus.m_axis_tlast  = tlast_q;
   assign bus.o_rd_len      = cur_q.len;
   assign o_commit_cnt      = commit_cnt_q;
   assign o_drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_rx_pbm_ring.sv
// -----------------------------------------------------------------------------
// tb_rx_pbm_ring
//   Directed bench for rx_pbm_ring built with a 16-word RAM and a 2-entry
//   descriptor FIFO so wrap, overflow and FIFO-full cases are short.
//   A packet table drives the main commit/drop cases; hand sequences cover
//   replay latency, overflow and wrap, stalls, FIFO full and mid-packet reset.
//   A negedge monitor compares every replayed beat with a scoreboard queue
//   and checks that tdata/tlast/o_rd_len hold during stalls.
// -----------------------------------------------------------------------------
module tb_rx_pbm_ring;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rx_pbm_ring_if #(.DATA_WIDTH(32)) bus ();
   logic [15:0] commit_cnt, drop_cnt;

   rx_pbm_ring #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(4),
      .DESC_DEPTH(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .o_commit_cnt (commit_cnt),
      .o_drop_cnt   (drop_cnt)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [15:0] len;
   } beat_t;

   typedef struct {
      int          n;
      logic [31:0] base;
      logic [15:0] len;
      logic        mv;
      logic        err;
      logic        ok;
   } pkt_vec_t;

   int          n_total = 0;
   int          n_pass  = 0;
   int          n_rx    = 0;
   beat_t       exp_q[$];
   logic [15:0] exp_commit = '0;
   logic [15:0] exp_drop   = '0;

   logic        stall_prev = 1'b0;
   logic [31:0] held_data;
   logic        held_last;
   logic [15:0] held_len;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Output monitor: samples on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 32'(bus.m_axis_tvalid), 32'd1);
            check("hold_data",  bus.m_axis_tdata, held_data);
            check("hold_last",  32'(bus.m_axis_tlast), 32'(held_last));
            check("hold_len",   32'(bus.o_rd_len), 32'(held_len));
         end
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            n_rx++;
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("axis_data", bus.m_axis_tdata, e.data);
               check("axis_last", 32'(bus.m_axis_tlast), 32'(e.last));
               check("axis_len",  32'(bus.o_rd_len), 32'(e.len));
            end
         end
         stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
         held_data  = bus.m_axis_tdata;
         held_last  = bus.m_axis_tlast;
         held_len   = bus.o_rd_len;
      end
   end

   // Sends one packet back to back; starts and ends 1 time unit after a rising edge.
   // Beats before the last carry werror=1 and garbage metadata, which must be ignored.
   task automatic send_pkt(input int n, input logic [31:0] base, input logic [15:0] len,
                           input logic mv, input logic err, input logic ok);
      for (int i = 0; i < n; i++) begin
         bus.i_pbm_wvalid = 1'b1;
         bus.i_pbm_wdata  = base + 32'(i);
         bus.i_pbm_wlast  = (i == n - 1);
         bus.i_pbm_werror = (i == n - 1) ? err : 1'b1;
         bus.i_meta_data  = (i == n - 1) ? len : 16'hFFFF;
         bus.i_meta_valid = (i == n - 1) ? mv : 1'b0;
         #1;
         check("pbm_ready",  32'(bus.o_pbm_ready), 32'd1);
         check("meta_ready", 32'(bus.o_meta_ready), 32'(i == n - 1));
         @(posedge clk); #1;
      end
      bus.i_pbm_wvalid = 1'b0;
      bus.i_pbm_wlast  = 1'b0;
      bus.i_pbm_werror = 1'b0;
      bus.i_meta_valid = 1'b0;
      if (ok) begin
         for (int i = 0; i < n; i++) exp_q.push_back('{base + 32'(i), (i == n - 1), len});
         exp_commit++;
      end else begin
         exp_drop++;
      end
      check("commit_cnt", 32'(commit_cnt), 32'(exp_commit));
      check("drop_cnt",   32'(drop_cnt),   32'(exp_drop));
   endtask

   // Waits for all expected beats to leave, bounded; leftovers count as a failure.
   task automatic wait_drain();
      int c = 0;
      repeat (8) begin @(posedge clk); #1; end
      while ((exp_q.size() != 0 || bus.m_axis_tvalid) && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pkt_vec_t vecs[8];
      int       n0;

      // 4 bytes per word; entries marked ok=0 must be rolled back
      vecs[0] = '{4, 32'h0000_0100, 16'd16, 1'b1, 1'b0, 1'b1}; // clean
      vecs[1] = '{4, 32'h0000_0200, 16'd16, 1'b1, 1'b1, 1'b0}; // werror on last
      vecs[2] = '{4, 32'h0000_0300, 16'd13, 1'b1, 1'b0, 1'b1}; // same RAM slot as [1]
      vecs[3] = '{3, 32'h0000_0400, 16'd13, 1'b1, 1'b0, 1'b0}; // 12 bytes < 13
      vecs[4] = '{3, 32'h0000_0500, 16'd12, 1'b0, 1'b0, 1'b0}; // meta not valid
      vecs[5] = '{1, 32'h0000_0600, 16'd4,  1'b1, 1'b0, 1'b1}; // single beat
      vecs[6] = '{5, 32'h0000_0700, 16'd8,  1'b1, 1'b0, 1'b1}; // padding replayed
      vecs[7] = '{1, 32'h0000_0800, 16'd0,  1'b1, 1'b0, 1'b1}; // zero length

      bus.i_pbm_wdata   = '0;
      bus.i_pbm_wvalid  = 1'b1;   // held during reset: must not be accepted
      bus.i_pbm_wlast   = 1'b1;
      bus.i_pbm_werror  = 1'b0;
      bus.i_meta_data   = '0;
      bus.i_meta_valid  = 1'b1;
      bus.m_axis_tready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_pbm_ready",  32'(bus.o_pbm_ready), 32'd0);
      check("rst_meta_ready", 32'(bus.o_meta_ready), 32'd0);
      check("rst_tvalid",     32'(bus.m_axis_tvalid), 32'd0);
      check("rst_tlast",      32'(bus.m_axis_tlast), 32'd0);
      check("rst_tdata",      bus.m_axis_tdata, 32'd0);
      check("rst_rd_len",     32'(bus.o_rd_len), 32'd0);
      check("rst_commit",     32'(commit_cnt), 32'd0);
      check("rst_drop",       32'(drop_cnt), 32'd0);
      bus.i_pbm_wvalid = 1'b0;
      bus.i_pbm_wlast  = 1'b0;
      bus.i_meta_valid = 1'b0;
      rst_n = 1'b1;
      check("ready_before_edge", 32'(bus.o_pbm_ready), 32'd0);
      @(posedge clk); #1;
      check("ready_after_edge", 32'(bus.o_pbm_ready), 32'd1);

      // basic packet and replay latency: EOP edge, pop, fetch, then tvalid
      send_pkt(4, 32'h0000_00A0, 16'd16, 1'b1, 1'b0, 1'b1);
      check("lat_eop_plus0", 32'(bus.m_axis_tvalid), 32'd0);
      @(posedge clk); #1;
      check("lat_eop_plus1", 32'(bus.m_axis_tvalid), 32'd0);
      @(posedge clk); #1;
      check("lat_eop_plus2", 32'(bus.m_axis_tvalid), 32'd1);
      wait_drain();

      // table-driven commit/drop cases
      for (int v = 0; v < 8; v++) begin
         send_pkt(vecs[v].n, vecs[v].base, vecs[v].len, vecs[v].mv, vecs[v].err, vecs[v].ok);
         wait_drain();
      end

      // overflow: 20 words into 16-word RAM drop without stalling, then wrap traffic
      send_pkt(20, 32'h0000_1000, 16'd80, 1'b1, 1'b0, 1'b0);
      wait_drain();
      send_pkt(4, 32'h0000_1100, 16'd16, 1'b1, 1'b0, 1'b1);
      wait_drain();
      for (int k = 0; k < 16; k++) begin
         send_pkt(4, 32'h0000_2000 + 32'(k * 16), 16'd16, 1'b1, 1'b0, 1'b1);
         wait_drain();
      end

      // alternating tready: words must hold during stalls and arrive once each
      bus.m_axis_tready = 1'b0;
      n0 = n_rx;
      send_pkt(8, 32'h0000_3000, 16'd32, 1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
         bus.m_axis_tready = ~bus.m_axis_tready;
         @(posedge clk); #1;
      end
      bus.m_axis_tready = 1'b1;
      wait_drain();
      check("stall_beats", 32'(n_rx - n0), 32'd8);

      // FIFO full: the read side has already popped packet 1, so packets 2 and 3
      // fill the two descriptor slots and packet 4 is dropped at its EOP
      bus.m_axis_tready = 1'b0;
      n0 = n_rx;
      send_pkt(4, 32'h0000_4000, 16'd16, 1'b1, 1'b0, 1'b1);
      send_pkt(4, 32'h0000_4100, 16'd16, 1'b1, 1'b0, 1'b1);
      send_pkt(4, 32'h0000_4200, 16'd16, 1'b1, 1'b0, 1'b1);
      send_pkt(4, 32'h0000_4300, 16'd16, 1'b1, 1'b0, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      bus.m_axis_tready = 1'b1;
      wait_drain();
      check("fifo_full_beats", 32'(n_rx - n0), 32'd12);

      // reset in the middle of a packet: partial data never replayed
      bus.i_pbm_wvalid = 1'b1;
      bus.i_pbm_wlast  = 1'b0;
      bus.i_pbm_wdata  = 32'h0000_5EE0;
      @(posedge clk); #1;
      bus.i_pbm_wdata  = 32'h0000_5EE1;
      @(posedge clk); #1;
      bus.i_pbm_wvalid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_commit = '0;
      exp_drop   = '0;
      check("mid_rst_commit", 32'(commit_cnt), 32'd0);
      check("mid_rst_drop",   32'(drop_cnt), 32'd0);
      check("mid_rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      check("mid_rst_rd_len", 32'(bus.o_rd_len), 32'd0);
      check("mid_rst_ready",  32'(bus.o_pbm_ready), 32'd0);
      @(posedge clk); #1;
      check("post_rst_ready", 32'(bus.o_pbm_ready), 32'd1);
      send_pkt(4, 32'h0000_6000, 16'd16, 1'b1, 1'b0, 1'b1);
      wait_drain();

      repeat (20) begin @(posedge clk); #1; end
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
